// File: rtl/temac_tx_frame_feeder.sv
// Store-and-forward TX frame buffer between the UDP/IP packer and the TEMAC client TX port.
// Buffers one whole frame, then plays it to the MAC, replaying on retransmit requests.
module temac_tx_frame_feeder #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned STATUS_TO = 4095
) (
  input  logic       tx_mac_clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_en,
  input  logic       tx_rdy,
  input  logic       tx_clk_en,
  output logic       tx_stop,
  input  logic       tx_retransmit,
  input  logic       tx_collision,
  input  logic       tx_status_vld,
  output logic       frame_done,
  output logic       frame_err,
  output logic       frame_drop,
  output logic [3:0] retry_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned TimerW = $clog2(STATUS_TO + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFill   = 3'd1;
  localparam logic [2:0] StDrop   = 3'd2;
  localparam logic [2:0] StLoad   = 3'd3;
  localparam logic [2:0] StSend   = 3'd4;
  localparam logic [2:0] StWait   = 3'd5;
  localparam logic [2:0] StRewind = 3'd6;

  localparam logic [ADDR_W-1:0] WrOne    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WrMax    = '1;
  localparam logic [ADDR_W:0]   RdOne    = (ADDR_W + 1)'(1);
  localparam logic [TimerW-1:0] TimerOne = TimerW'(1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(STATUS_TO);
  localparam logic [3:0]        RetryOne = 4'd1;
  localparam logic [3:0]        RetryMax = 4'(MAX_RETRY);

  logic [7:0] mem [Depth];

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              tx_stop_q, tx_stop_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              s_ready_q, s_ready_d;

  logic       accept_in;
  logic       accept_out;
  logic       wr_en;
  logic       do_abort;
  logic [7:0] rd_byte;

  assign accept_in  = s_valid & s_ready_q;
  assign accept_out = tx_en_q & tx_rdy & tx_clk_en;
  assign wr_en      = accept_in & ((state_q == StIdle) | (state_q == StFill));
  assign rd_byte    = mem[rd_ptr_q[ADDR_W-1:0]];

  // Frame storage is deliberately not reset; length and pointers define what is valid.
  always_ff @(posedge tx_mac_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    rd_ptr_d  = rd_ptr_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    tx_stop_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    drop_d    = 1'b0;
    do_abort  = 1'b0;

    case (state_q)
      StIdle, StFill: begin
        if (accept_in) begin
          wr_ptr_d = wr_ptr_q + WrOne;
          if (state_q == StIdle) begin
            retry_d = '0;
          end
          if (s_last) begin
            len_d    = {1'b0, wr_ptr_q} + RdOne;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = StLoad;
          end else if (wr_ptr_q == WrMax) begin
            state_d = StDrop;
          end else begin
            state_d = StFill;
          end
        end
      end
      StDrop: begin
        if (accept_in && s_last) begin
          drop_d   = 1'b1;
          wr_ptr_d = '0;
          state_d  = StIdle;
        end
      end
      StLoad: begin
        // Present byte 0 and point at byte 1 so the next accept has no bubble.
        tx_data_d = rd_byte;
        rd_ptr_d  = rd_ptr_q + RdOne;
        tx_en_d   = 1'b1;
        state_d   = StSend;
      end
      StSend, StWait: begin
        if (tx_retransmit) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RetryOne;
            tx_en_d = 1'b0;
            state_d = StRewind;
          end else begin
            do_abort = 1'b1;
          end
        end else if (tx_collision) begin
          do_abort = 1'b1;
        end else if (state_q == StSend) begin
          if (accept_out) begin
            if (rd_ptr_q == len_q) begin
              tx_en_d = 1'b0;
              timer_d = '0;
              state_d = StWait;
            end else begin
              tx_data_d = rd_byte;
              rd_ptr_d  = rd_ptr_q + RdOne;
            end
          end
        end else begin
          if (tx_status_vld) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (timer_q == TimerMax) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            timer_d = timer_q + TimerOne;
          end
        end
      end
      StRewind: begin
        rd_ptr_d = '0;
        state_d  = StLoad;
      end
      default: state_d = StIdle;
    endcase

    if (do_abort) begin
      tx_stop_d = tx_en_q;
      tx_en_d   = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
      state_d   = StIdle;
    end

    s_ready_d = (state_d == StIdle) | (state_d == StFill) | (state_d == StDrop);
  end

  always_ff @(posedge tx_mac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      len_q     <= '0;
      rd_ptr_q  <= '0;
      timer_q   <= '0;
      retry_q   <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      tx_stop_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      len_q     <= len_d;
      rd_ptr_q  <= rd_ptr_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_stop_q <= tx_stop_d;
      done_q    <= done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign tx_data    = tx_data_q;
  assign tx_data_en = tx_en_q;
  assign tx_stop    = tx_stop_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_drop = drop_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_temac_tx_frame_feeder.sv
// Bench for temac_tx_frame_feeder: scenario table, hand-written corner sequences and
// randomized frames checked against an outcome model built from the frame contents.
module tb_temac_tx_frame_feeder;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned MAX_RETRY = 15;
  localparam int unsigned STATUS_TO = 4095;

  logic       tx_mac_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0] tx_data;
  logic       tx_data_en, tx_stop, frame_done, frame_err, frame_drop;
  logic       tx_rdy = 1'b0, tx_clk_en = 1'b0, tx_retransmit = 1'b0;
  logic       tx_collision = 1'b0, tx_status_vld = 1'b0;
  logic [3:0] retry_cnt;

  always #5 tx_mac_clk = ~tx_mac_clk;

  temac_tx_frame_feeder #(
    .ADDR_W   (ADDR_W),
    .MAX_RETRY(MAX_RETRY),
    .STATUS_TO(STATUS_TO)
  ) dut (
    .tx_mac_clk   (tx_mac_clk),
    .reset_n      (reset_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_data      (tx_data),
    .tx_data_en   (tx_data_en),
    .tx_rdy       (tx_rdy),
    .tx_clk_en    (tx_clk_en),
    .tx_stop      (tx_stop),
    .tx_retransmit(tx_retransmit),
    .tx_collision (tx_collision),
    .tx_status_vld(tx_status_vld),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_drop   (frame_drop),
    .retry_cnt    (retry_cnt)
  );

  typedef struct {
    int len; int base; int div; int rdy_hold;
    int retx_n; int retx_at; int coll_at; bit status;
    bit exp_err; int exp_retry; bit exp_stop;
  } case_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] frame[$];
  logic [7:0] cap[$];
  int r_done, r_err, r_retry, r_stop, r_hold_bad, r_wait, r_lat, r_bad, r_drop, r_en_in;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outcome of a frame from the replay/abort rules alone.
  function automatic case_t model(input case_t c);
    case_t m = c;
    m.exp_retry = (c.retx_n > int'(MAX_RETRY)) ? int'(MAX_RETRY) : c.retx_n;
    m.exp_stop  = (c.retx_n > int'(MAX_RETRY)) || (c.coll_at > 0);
    m.exp_err   = m.exp_stop || !c.status;
    return m;
  endfunction

  // Streams len bytes upstream; returns at posedge+1 after the s_last accept edge.
  task automatic send_frame(input int len, input int base);
    int guard;
    bit acc;
    r_drop = 0;
    r_en_in = 0;
    for (int i = 0; i < len; i++) begin
      s_data  = 8'(base + i);
      s_valid = 1'b1;
      s_last  = (i == len - 1);
      guard   = 0;
      do begin
        @(negedge tx_mac_clk);
        acc = s_ready;
        if (frame_drop) r_drop++;
        if (tx_data_en) r_en_in++;
        @(posedge tx_mac_clk);
        #1;
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) begin
        check("s_ready_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_case(input string name, input case_t c);
    int cyc = 0, en_seen = 0, retx_left = c.retx_n, wait_cnt = 0;
    bit coll_pending = (c.coll_at > 0), status_sent = 0;
    bit act_retx = 0, act_coll = 0, act_status = 0;
    bit prev_en = 0, prev_acc = 0, acc;
    logic [7:0] prev_d = '0;
    frame.delete();
    cap.delete();
    for (int i = 0; i < c.len; i++) frame.push_back(8'(c.base + i));
    send_frame(c.len, c.base);
    r_done = 0; r_err = -1; r_retry = -1; r_stop = 0; r_hold_bad = 0; r_lat = -1;
    while (!r_done && cyc < 20000) begin
      tx_clk_en = (c.div == 0) ? 1'($urandom % 2) : ((cyc % c.div) == c.div - 1);
      tx_rdy    = (c.div == 0) ? ($urandom % 4 != 0) : (en_seen >= c.rdy_hold);
      tx_retransmit = act_retx;
      tx_collision  = act_coll;
      tx_status_vld = act_status;
      if (act_retx || act_coll) tx_rdy = 1'b0;
      act_retx = 0; act_coll = 0; act_status = 0;
      @(negedge tx_mac_clk);
      cyc++;
      if (r_lat < 0 && tx_data_en) r_lat = cyc;
      acc = tx_data_en & tx_rdy & tx_clk_en;
      if (tx_data_en && prev_en && !prev_acc && tx_data != prev_d) r_hold_bad++;
      prev_en = tx_data_en; prev_acc = acc; prev_d = tx_data;
      if (tx_data_en && tx_clk_en) en_seen++;
      if (acc) cap.push_back(tx_data);
      if (tx_retransmit) cap.delete();
      if (tx_stop) r_stop++;
      if (!tx_data_en && cap.size() == c.len) wait_cnt++;
      if (frame_done) begin
        r_done = 1; r_err = frame_err; r_retry = retry_cnt;
      end
      if (tx_data_en && retx_left > 0 && cap.size() == c.retx_at) begin
        act_retx = 1; retx_left--;
      end else if (tx_data_en && coll_pending && cap.size() == c.coll_at) begin
        act_coll = 1; coll_pending = 0;
      end else if (c.status && !status_sent && !tx_data_en && cap.size() == c.len) begin
        act_status = 1; status_sent = 1;
      end
      @(posedge tx_mac_clk);
      #1;
    end
    tx_rdy = 0; tx_clk_en = 0; tx_retransmit = 0; tx_collision = 0; tx_status_vld = 0;
    r_wait = wait_cnt;
    r_bad = 0;
    for (int i = 0; i < cap.size() && i < frame.size(); i++) if (cap[i] != frame[i]) r_bad++;
    check({name, "_done"}, r_done, 1);
    check({name, "_err"}, r_err, int'(c.exp_err));
    check({name, "_retry"}, r_retry, c.exp_retry);
    check({name, "_stop"}, r_stop, int'(c.exp_stop));
    check({name, "_hold"}, r_hold_bad, 0);
    check({name, "_latency"}, r_lat, 2);
    if (!c.exp_err) begin
      check({name, "_nbytes"}, cap.size(), c.len);
      check({name, "_bytes"}, r_bad, 0);
    end
  endtask

  case_t tbl[9];
  case_t rc;
  int    tmp;

  initial begin
    //         len   base div hold retx at  coll st  err retry stop
    tbl[0] = '{60,   0,   1,  0,   0,   0,  0,   1,  0,  0,    0};
    tbl[1] = '{60,   0,   10, 5,   0,   0,  0,   1,  0,  0,    0};
    tbl[2] = '{60,   0,   1,  0,   1,   20, 0,   1,  0,  1,    0};
    tbl[3] = '{60,   0,   1,  0,   16,  5,  0,   1,  1,  15,   1};
    tbl[4] = '{60,   0,   1,  0,   0,   0,  10,  1,  1,  0,    1};
    tbl[5] = '{1,    165, 1,  0,   0,   0,  0,   1,  0,  0,    0};
    tbl[6] = '{2048, 7,   1,  0,   0,   0,  0,   1,  0,  0,    0};
    tbl[7] = '{60,   48,  1,  0,   15,  3,  0,   1,  0,  15,   0};
    tbl[8] = '{60,   9,   1,  0,   1,   59, 0,   1,  0,  1,    0};

    // Reset state.
    #1;
    check("rst_outputs", {s_ready, tx_data_en, tx_stop, frame_done, frame_err, frame_drop}, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_retry", retry_cnt, 0);
    repeat (3) @(negedge tx_mac_clk);
    reset_n = 1'b1;
    @(posedge tx_mac_clk);
    #1;
    @(negedge tx_mac_clk);
    check("idle_s_ready", s_ready, 1);
    @(posedge tx_mac_clk);
    #1;

    for (int i = 0; i < 9; i++) run_case($sformatf("tbl%0d", i), tbl[i]);

    // Oversize frame is dropped, never reaches the MAC, then the next frame goes out.
    send_frame(2 ** ADDR_W + 1, 0);
    tmp = r_en_in;
    for (int i = 0; i < 4; i++) begin
      @(negedge tx_mac_clk);
      if (frame_drop) r_drop++;
      if (tx_data_en || frame_done) tmp++;
      @(posedge tx_mac_clk);
      #1;
    end
    check("drop_pulse", r_drop, 1);
    check("drop_no_tx", tmp, 0);
    rc = '{64, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    run_case("after_drop", rc);

    // No status from the MAC: error after the timeout window.
    rc = '{60, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    run_case("timeout", rc);
    check("timeout_cycles", r_wait, int'(STATUS_TO) + 2);

    // Reset in the middle of SEND.
    send_frame(60, 0);
    tx_rdy = 1'b1;
    tx_clk_en = 1'b1;
    repeat (10) @(posedge tx_mac_clk);
    @(negedge tx_mac_clk);
    check("pre_rst_en", tx_data_en, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {s_ready, tx_data_en, tx_stop, frame_done, frame_err}, 0);
    check("midrst_retry", retry_cnt, 0);
    tx_rdy = 1'b0;
    tx_clk_en = 1'b0;
    repeat (2) @(negedge tx_mac_clk);
    reset_n = 1'b1;
    @(posedge tx_mac_clk);
    #1;
    rc = '{60, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    run_case("post_rst", rc);

    // Randomized frames, MAC enables and replays.
    for (int k = 0; k < 6; k++) begin
      rc.len      = 1 + int'($urandom_range(149));
      rc.base     = int'($urandom_range(255));
      rc.div      = 0;
      rc.rdy_hold = 0;
      rc.retx_n   = (rc.len > 1) ? int'($urandom_range(2)) : 0;
      rc.retx_at  = (rc.len > 1) ? 1 + int'($urandom_range(rc.len - 2)) : 0;
      rc.coll_at  = 0;
      rc.status   = 1'b1;
      rc = model(rc);
      run_case($sformatf("rand%0d", k), rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
